// File: rtl/calc_seq_pkg.sv
// Shared types for the calculator arithmetic sequencer: operation codes, FSM states, default width.
package calc_seq_pkg;

    localparam int WIDTH_DEF = 8;

    typedef enum logic [1:0] {
        OP_ADD  = 2'b00,
        OP_SUB  = 2'b01,
        OP_MULT = 2'b10,
        OP_DIV  = 2'b11
    } op_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_M_LOAD,
        S_M_ADD,
        S_M_SHIFT,
        S_D_LOAD,
        S_D_SHIFT,
        S_D_TRIAL,
        S_FIN
    } state_e;

endpackage

// File: rtl/arith_sequencer_if.sv
// Control-unit request/status and datapath strobe bundle between the sequencer and its neighbours.
interface arith_sequencer_if;
    import calc_seq_pkg::*;

    logic abort;
    logic start;
    op_e  op;
    logic q0;
    logic alu_neg;
    logic divisor_zero;
    logic m_load;
    logic m_add;
    logic m_sub;
    logic m_shift;
    logic d_load;
    logic d_shift;
    logic d_commit;
    logic busy;
    logic done;
    logic dbz;
    op_e  result_sel;

    modport slave (
        input  abort, start, op, q0, alu_neg, divisor_zero,
        output m_load, m_add, m_sub, m_shift, d_load, d_shift, d_commit,
        output busy, done, dbz, result_sel
    );

    modport master (
        output abort, start, op, q0, alu_neg, divisor_zero,
        input  m_load, m_add, m_sub, m_shift, d_load, d_shift, d_commit,
        input  busy, done, dbz, result_sel
    );

endinterface

// File: rtl/iter_counter.sv
// Iteration counter: synchronous clear, saturating increment, terminal-count flag at WIDTH-1.
module iter_counter #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic clk2,
    input  logic reset,
    input  logic clear,
    input  logic inc,
    output logic tc
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk2 or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (inc && !tc) begin
            count <= count + 1'b1;
        end
    end

    assign tc = (count == LAST);

endmodule

// File: rtl/arith_sequencer.sv
// Multi-cycle sequencer for the shift-add multiplier and shift-subtract divider datapaths.
//
// state     | meaning
// S_IDLE    | waiting for start; add/sub go straight to S_FIN
// S_M_LOAD  | load multiplicand/multiplier, clear accumulator and count
// S_M_ADD   | conditional add (sign-correcting subtract on last iteration)
// S_M_SHIFT | arithmetic right shift of {A,Q}, advance or finish
// S_D_LOAD  | load dividend/divisor, trap zero divisor
// S_D_SHIFT | left shift of {R,Q}
// S_D_TRIAL | commit trial difference when non-negative, advance or finish
// S_FIN     | one-cycle done, publish result select
module arith_sequencer
    import calc_seq_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input logic              clk2,
    input logic              reset,
    arith_sequencer_if.slave bus
);

    state_e state_q, state_d;
    op_e    op_q, result_sel_q;
    logic   dbz_q;

    logic cnt_clear, cnt_inc, cnt_tc;
    logic latch_op, set_dbz;
    logic m_load, m_add, m_sub, m_shift;
    logic d_load, d_shift, d_commit;
    logic done, dbz;

    iter_counter #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_iter (
        .clk2  (clk2),
        .reset (reset),
        .clear (cnt_clear),
        .inc   (cnt_inc),
        .tc    (cnt_tc)
    );

    always_ff @(posedge clk2 or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk2 or posedge reset) begin
        if (reset) begin
            op_q         <= OP_ADD;
            result_sel_q <= OP_ADD;
            dbz_q        <= 1'b0;
        end else begin
            if (latch_op) begin
                op_q  <= bus.op;
                dbz_q <= 1'b0;
            end
            if (set_dbz) begin
                dbz_q <= 1'b1;
            end
            if (state_q == S_FIN && !bus.abort) begin
                result_sel_q <= op_q;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_clear = 1'b0;
        cnt_inc   = 1'b0;
        latch_op  = 1'b0;
        set_dbz   = 1'b0;
        m_load    = 1'b0;
        m_add     = 1'b0;
        m_sub     = 1'b0;
        m_shift   = 1'b0;
        d_load    = 1'b0;
        d_shift   = 1'b0;
        d_commit  = 1'b0;
        done      = 1'b0;
        dbz       = 1'b0;

        case (state_q)
            S_IDLE: begin
                cnt_clear = 1'b1;
                if (bus.start) begin
                    latch_op = 1'b1;
                    case (bus.op)
                        OP_MULT: state_d = S_M_LOAD;
                        OP_DIV:  state_d = S_D_LOAD;
                        default: state_d = S_FIN;
                    endcase
                end
            end
            S_M_LOAD: begin
                m_load    = 1'b1;
                cnt_clear = 1'b1;
                state_d   = S_M_ADD;
            end
            S_M_ADD: begin
                // Last multiplier bit carries negative weight in two's complement.
                if (bus.q0) begin
                    m_sub = cnt_tc;
                    m_add = !cnt_tc;
                end
                state_d = S_M_SHIFT;
            end
            S_M_SHIFT: begin
                m_shift = 1'b1;
                if (cnt_tc) begin
                    state_d = S_FIN;
                end else begin
                    cnt_inc = 1'b1;
                    state_d = S_M_ADD;
                end
            end
            S_D_LOAD: begin
                d_load    = 1'b1;
                cnt_clear = 1'b1;
                if (bus.divisor_zero) begin
                    set_dbz = 1'b1;
                    state_d = S_FIN;
                end else begin
                    state_d = S_D_SHIFT;
                end
            end
            S_D_SHIFT: begin
                d_shift = 1'b1;
                state_d = S_D_TRIAL;
            end
            S_D_TRIAL: begin
                d_commit = !bus.alu_neg;
                if (cnt_tc) begin
                    state_d = S_FIN;
                end else begin
                    cnt_inc = 1'b1;
                    state_d = S_D_SHIFT;
                end
            end
            S_FIN: begin
                done    = !bus.abort;
                dbz     = dbz_q && !bus.abort;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // Keypad clear wins over everything, including a start in IDLE.
        if (bus.abort) begin
            state_d   = S_IDLE;
            cnt_clear = 1'b1;
            cnt_inc   = 1'b0;
            latch_op  = 1'b0;
            set_dbz   = 1'b0;
        end
    end

    assign bus.m_load     = m_load;
    assign bus.m_add      = m_add;
    assign bus.m_sub      = m_sub;
    assign bus.m_shift    = m_shift;
    assign bus.d_load     = d_load;
    assign bus.d_shift    = d_shift;
    assign bus.d_commit   = d_commit;
    assign bus.busy       = (state_q != S_IDLE);
    assign bus.done       = done;
    assign bus.dbz        = dbz;
    assign bus.result_sel = result_sel_q;

endmodule

// File: tb/tb_arith_sequencer.sv
// Self-checking bench: behavioural multiplier/divider datapath model driven by the sequencer strobes.
module tb_arith_sequencer;
    import calc_seq_pkg::*;

    logic clk2  = 1'b0;
    logic reset = 1'b1;

    arith_sequencer_if bus ();

    arith_sequencer #(.WIDTH(8)) dut (
        .clk2  (clk2),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk2 = ~clk2;

    int checks   = 0;
    int failures = 0;

    // Datapath model state
    int         a_acc;
    int         r_rem;
    logic [7:0] q_reg;
    logic [7:0] m_reg;
    logic [7:0] d_reg;

    // Per-operation trace
    int   n_mload, n_madd, n_msub, n_mshift;
    int   n_dload, n_dshift, n_dcommit;
    int   n_done, done_cyc;
    logic dbz_at_done;

    function automatic logic [6:0] strobes();
        return {bus.m_load, bus.m_add, bus.m_sub, bus.m_shift,
                bus.d_load, bus.d_shift, bus.d_commit};
    endfunction

    task automatic run_op(input op_e o, input logic [15:0] a_in, input logic [7:0] b_in,
                          input int start_at, input int abort_at);
        n_mload = 0; n_madd = 0; n_msub = 0; n_mshift = 0;
        n_dload = 0; n_dshift = 0; n_dcommit = 0;
        n_done = 0; done_cyc = -1; dbz_at_done = 1'b0;
        @(negedge clk2);
        bus.op    = o;
        bus.start = 1'b1;
        bus.abort = 1'b0;
        @(posedge clk2);
        #1;
        bus.start = 1'b0;
        bus.op    = op_e'(2'($urandom_range(0, 3)));
        for (int c = 0; c < 40; c++) begin
            @(negedge clk2);
            bus.q0           = q_reg[0];
            bus.alu_neg      = (r_rem < int'(d_reg));
            bus.divisor_zero = (b_in == 8'h00);
            bus.start        = (c == start_at);
            bus.abort        = (c == abort_at);
            #1;
            checks++;
            if ($countones(strobes()) > 1) begin
                failures++;
                $display("FAIL strobe_onehot cycle=%0d got=%b want at most one high", c, strobes());
            end
            checks++;
            if (bus.busy !== (abort_at < 0 || c <= abort_at)) begin
                failures++;
                $display("FAIL busy cycle=%0d got=%b want=%b", c, bus.busy, (abort_at < 0 || c <= abort_at));
            end
            checks++;
            if (bus.dbz === 1'b1 && bus.done !== 1'b1) begin
                failures++;
                $display("FAIL dbz_without_done cycle=%0d got dbz=%b done=%b want dbz only with done", c, bus.dbz, bus.done);
            end
            if (bus.m_load) begin
                n_mload++;
                a_acc = 0;
                m_reg = a_in[7:0];
                q_reg = b_in;
            end
            if (bus.m_add) begin
                n_madd++;
                a_acc += int'($signed(m_reg));
            end
            if (bus.m_sub) begin
                n_msub++;
                a_acc -= int'($signed(m_reg));
            end
            if (bus.m_shift) begin
                n_mshift++;
                q_reg = {a_acc[0], q_reg[7:1]};
                a_acc = a_acc >>> 1;
            end
            if (bus.d_load) begin
                n_dload++;
                r_rem = int'(a_in[15:8]);
                q_reg = a_in[7:0];
                d_reg = b_in;
            end
            if (bus.d_shift) begin
                n_dshift++;
                r_rem = r_rem * 2 + int'(q_reg[7]);
                q_reg = {q_reg[6:0], 1'b0};
            end
            if (bus.d_commit) begin
                n_dcommit++;
                r_rem -= int'(d_reg);
                q_reg[0] = 1'b1;
            end
            if (bus.done === 1'b1) begin
                n_done++;
                dbz_at_done = bus.dbz;
                done_cyc = c;
                break;
            end
            if (abort_at >= 0 && c >= abort_at + 4) break;
        end
        bus.start = 1'b0;
        bus.abort = 1'b0;
        if (abort_at < 0) begin
            checks++;
            if (done_cyc < 0) begin
                failures++;
                $display("FAIL done_timeout op=%0d got no done want done within 40 cycles", o);
            end
        end
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.dbz !== 1'b0) begin
            failures++;
            $display("FAIL reset_status got busy=%b done=%b dbz=%b want 000", bus.busy, bus.done, bus.dbz);
        end
        checks++;
        if (strobes() !== 7'b0) begin
            failures++;
            $display("FAIL reset_strobes got=%b want=0000000", strobes());
        end
        checks++;
        if (bus.result_sel !== OP_ADD) begin
            failures++;
            $display("FAIL reset_result_sel got=%b want=00", bus.result_sel);
        end
        @(negedge clk2);
        reset = 1'b0;
        repeat (2) @(negedge clk2);
        #1;
        checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            failures++;
            $display("FAIL idle_after_reset got busy=%b done=%b want 00", bus.busy, bus.done);
        end
    endtask

    task automatic test_add_sub();
        op_e o;
        for (int i = 0; i < 4; i++) begin
            o = (i % 2 == 0) ? OP_ADD : OP_SUB;
            run_op(o, 16'($urandom), 8'($urandom), -1, -1);
            checks++;
            if (done_cyc !== 0) begin
                failures++;
                $display("FAIL addsub_latency op=%0d got=%0d want=0", o, done_cyc);
            end
            checks++;
            if (n_mload + n_madd + n_msub + n_mshift + n_dload + n_dshift + n_dcommit != 0) begin
                failures++;
                $display("FAIL addsub_strobes op=%0d got some strobe want none", o);
            end
            @(negedge clk2);
            #1;
            checks++;
            if (bus.result_sel !== o || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
                failures++;
                $display("FAIL addsub_after got sel=%b busy=%b done=%b want sel=%b busy=0 done=0",
                         bus.result_sel, bus.busy, bus.done, o);
            end
        end
    endtask

    task automatic test_mult_directed();
        logic [7:0]  a_t [3] = '{8'h05, 8'hFD, 8'h03};
        logic [7:0]  b_t [3] = '{8'h03, 8'h03, 8'hFD};
        logic [15:0] want_t [3] = '{16'h000F, 16'hFFF7, 16'hFFF7};
        logic [15:0] prod;
        for (int i = 0; i < 3; i++) begin
            run_op(OP_MULT, {8'h00, a_t[i]}, b_t[i], -1, -1);
            prod = 16'(a_acc * 256 + int'(q_reg));
            checks++;
            if (prod !== want_t[i]) begin
                failures++;
                $display("FAIL mult_product %h x %h got=%h want=%h", a_t[i], b_t[i], prod, want_t[i]);
            end
            checks++;
            if (done_cyc !== 17) begin
                failures++;
                $display("FAIL mult_latency got=%0d want=17", done_cyc);
            end
            checks++;
            if (n_msub != int'(b_t[i][7]) || n_madd != $countones(b_t[i][6:0]) ||
                n_mshift != 8 || n_mload != 1) begin
                failures++;
                $display("FAIL mult_strobe_counts got load=%0d add=%0d sub=%0d shift=%0d want 1/%0d/%0d/8",
                         n_mload, n_madd, n_msub, n_mshift, $countones(b_t[i][6:0]), b_t[i][7]);
            end
            @(negedge clk2);
            #1;
            checks++;
            if (bus.result_sel !== OP_MULT || bus.done !== 1'b0) begin
                failures++;
                $display("FAIL mult_after got sel=%b done=%b want sel=10 done=0", bus.result_sel, bus.done);
            end
        end
    endtask

    task automatic test_mult_random();
        logic [7:0]  a, b;
        logic [15:0] prod, want;
        for (int i = 0; i < 8; i++) begin
            a = 8'($urandom);
            b = 8'($urandom);
            run_op(OP_MULT, {8'h00, a}, b, -1, -1);
            prod = 16'(a_acc * 256 + int'(q_reg));
            want = 16'(int'($signed(a)) * int'($signed(b)));
            checks++;
            if (prod !== want || done_cyc !== 17) begin
                failures++;
                $display("FAIL mult_random %h x %h got=%h at %0d want=%h at 17", a, b, prod, done_cyc, want);
            end
        end
    endtask

    task automatic test_div_directed();
        logic [7:0] quo, rem;
        run_op(OP_DIV, 16'h0064, 8'h07, -1, -1);
        quo = q_reg;
        rem = 8'(r_rem);
        checks++;
        if (quo !== 8'h0E || rem !== 8'h02) begin
            failures++;
            $display("FAIL div_result got Q=%h R=%h want Q=0e R=02", quo, rem);
        end
        checks++;
        if (done_cyc !== 17 || n_done != 1 || dbz_at_done !== 1'b0) begin
            failures++;
            $display("FAIL div_done got cyc=%0d n=%0d dbz=%b want 17/1/0", done_cyc, n_done, dbz_at_done);
        end
        checks++;
        if (n_dshift != 8 || n_dcommit != 3 || n_dload != 1) begin
            failures++;
            $display("FAIL div_strobes got load=%0d shift=%0d commit=%0d want 1/8/3", n_dload, n_dshift, n_dcommit);
        end
        @(negedge clk2);
        #1;
        checks++;
        if (bus.done !== 1'b0 || bus.result_sel !== OP_DIV) begin
            failures++;
            $display("FAIL div_after got done=%b sel=%b want done=0 sel=11", bus.done, bus.result_sel);
        end
    endtask

    task automatic test_div_zero();
        run_op(OP_DIV, 16'($urandom), 8'h00, -1, -1);
        checks++;
        if (done_cyc !== 1 || dbz_at_done !== 1'b1) begin
            failures++;
            $display("FAIL div0_done got cyc=%0d dbz=%b want cyc=1 dbz=1", done_cyc, dbz_at_done);
        end
        checks++;
        if (n_dload != 1 || n_dshift != 0 || n_dcommit != 0) begin
            failures++;
            $display("FAIL div0_strobes got load=%0d shift=%0d commit=%0d want 1/0/0", n_dload, n_dshift, n_dcommit);
        end
        @(negedge clk2);
        #1;
        checks++;
        if (bus.dbz !== 1'b0 || bus.result_sel !== OP_DIV) begin
            failures++;
            $display("FAIL div0_after got dbz=%b sel=%b want dbz=0 sel=11", bus.dbz, bus.result_sel);
        end
    endtask

    task automatic test_div_random();
        logic [7:0]  b, quo, rem;
        logic [15:0] a;
        int          wq, wr;
        for (int i = 0; i < 8; i++) begin
            b  = 8'($urandom_range(1, 255));
            a  = {8'($urandom_range(0, int'(b) - 1)), 8'($urandom)};
            wq = int'(a) / int'(b);
            wr = int'(a) % int'(b);
            run_op(OP_DIV, a, b, -1, -1);
            quo = q_reg;
            rem = 8'(r_rem);
            checks++;
            if (quo !== 8'(wq) || rem !== 8'(wr) || dbz_at_done !== 1'b0) begin
                failures++;
                $display("FAIL div_random %h / %h got Q=%h R=%h dbz=%b want Q=%h R=%h dbz=0",
                         a, b, quo, rem, dbz_at_done, 8'(wq), 8'(wr));
            end
        end
    endtask

    task automatic test_reset_mid_op();
        @(negedge clk2);
        bus.op           = OP_DIV;
        bus.divisor_zero = 1'b0;
        bus.start        = 1'b1;
        @(posedge clk2);
        #1;
        bus.start = 1'b0;
        repeat (6) @(negedge clk2);
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.dbz !== 1'b0 || strobes() !== 7'b0) begin
            failures++;
            $display("FAIL midreset_outputs got busy=%b done=%b dbz=%b strobes=%b want all 0",
                     bus.busy, bus.done, bus.dbz, strobes());
        end
        checks++;
        if (bus.result_sel !== OP_ADD) begin
            failures++;
            $display("FAIL midreset_sel got=%b want=00", bus.result_sel);
        end
        @(negedge clk2);
        reset = 1'b0;
        run_op(OP_ADD, 16'($urandom), 8'($urandom), -1, -1);
        checks++;
        if (done_cyc !== 0) begin
            failures++;
            $display("FAIL midreset_add_latency got=%0d want=0", done_cyc);
        end
    endtask

    task automatic test_abort();
        logic [15:0] prod, want;
        run_op(OP_SUB, 16'h0000, 8'h00, -1, -1);
        run_op(OP_MULT, 16'h0005, 8'h03, 5, 9);
        checks++;
        if (n_done != 0) begin
            failures++;
            $display("FAIL abort_no_done got done count=%0d want 0", n_done);
        end
        checks++;
        if (bus.result_sel !== OP_SUB) begin
            failures++;
            $display("FAIL abort_sel_kept got=%b want=01", bus.result_sel);
        end
        run_op(OP_MULT, 16'h00FD, 8'hFD, -1, -1);
        prod = 16'(a_acc * 256 + int'(q_reg));
        want = 16'h0009;
        checks++;
        if (prod !== want || done_cyc !== 17) begin
            failures++;
            $display("FAIL abort_next_mult got=%h at %0d want=%h at 17", prod, done_cyc, want);
        end
    endtask

    initial begin
        bus.start        = 1'b0;
        bus.abort        = 1'b0;
        bus.op           = OP_ADD;
        bus.q0           = 1'b0;
        bus.alu_neg      = 1'b0;
        bus.divisor_zero = 1'b0;
        a_acc = 0; r_rem = 0; q_reg = '0; m_reg = '0; d_reg = '0;
        test_reset();
        test_add_sub();
        test_mult_directed();
        test_mult_random();
        test_div_directed();
        test_div_zero();
        test_div_random();
        test_reset_mid_op();
        test_abort();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got simulation still running want finished");
        $fatal(1, "watchdog expired");
    end

endmodule
